// File: rtl/alu_serial_pkg.sv
// Shared types, op codes and carry-in lookup for the bit-serial ALU sequencer.
// SERIAL_ALU_CARRY_CHAIN_EN routes a sticky carry into ADC/SBB.
package alu_serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic MODE_ARITH = 1'b0;
    localparam logic MODE_LOGIC = 1'b1;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_INC   = 3'b010;
    localparam logic [2:0] OP_SBB   = 3'b011;
    localparam logic [2:0] OP_ADDNB = 3'b100;
    localparam logic [2:0] OP_DEC   = 3'b101;
    localparam logic [2:0] OP_PASSB = 3'b110;
    localparam logic [2:0] OP_PASSA = 3'b111;

    typedef struct packed {
        logic carry;
        logic zero;
        logic sign;
        logic overflow;
    } alu_flags_t;

    // sticky is tied low when the carry chain is not built
    function automatic logic cin0_lookup(
        input logic       mode,
        input logic [2:0] op,
        input logic       sticky
    );
        logic r;
        r = 1'b0;
        if (mode == MODE_ARITH) begin
            case (op)
                OP_SUB, OP_INC: r = 1'b1;
                OP_ADD, OP_SBB: r = sticky;
                default:        r = 1'b0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_serial_sequencer_flags.sv
// Zero accumulation, MSB carry-in capture and flag formation for the serial ALU.
// Used by alu_serial_sequencer (see SERIAL_ALU_CARRY_CHAIN_EN there).
import alu_serial_pkg::*;

module serial_flag_tracker (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       shift_en,
    input  logic       last,
    input  logic       mode,
    input  logic       slice_out,
    input  logic       slice_cin,
    input  logic       carry,
    input  logic       msb,
    output alu_flags_t flags
);

    logic zero_acc;
    logic cin_msb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_acc <= 1'b0;
            cin_msb  <= 1'b0;
        end else if (start) begin
            zero_acc <= 1'b1;
            cin_msb  <= 1'b0;
        end else if (shift_en) begin
            zero_acc <= zero_acc & ~slice_out;
            if (last) begin
                cin_msb <= slice_cin;
            end
        end
    end

    always_comb begin
        flags          = '0;
        flags.zero     = zero_acc;
        flags.sign     = msb;
        if (mode == MODE_ARITH) begin
            flags.carry    = carry;
            flags.overflow = cin_msb ^ carry;
        end
    end

endmodule

// File: rtl/alu_serial_sequencer.sv
// Bit-serial sequencer feeding a one-bit ALU slice LSB first, with carry chaining.
// Optional SERIAL_ALU_CARRY_CHAIN_EN: sticky carry feeds ADC/SBB carry-in.
import alu_serial_pkg::*;

module alu_serial_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_mode,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_sign,
    output logic             rsp_overflow,
    output logic             busy,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic             slice_mode,
    output logic [2:0]       slice_op,
    input  logic             slice_out,
    input  logic             slice_carry
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             mode_q;
    logic [2:0]       op_q;
    logic [CW-1:0]    cnt_q;
    logic             cin0_q;
    logic             carry_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_result_q;
    alu_flags_t       rsp_flags_q;
    alu_flags_t       flags;
    logic             sticky;
    logic             start;
    logic             in_shift;
    logic             last;

    assign start    = (state_q == IDLE) && req_valid;
    assign in_shift = (state_q == SHIFT);
    assign last     = (cnt_q == CW'(WIDTH - 1));

`ifdef SERIAL_ALU_CARRY_CHAIN_EN
    logic sticky_q;

    // only arithmetic results carry into the next ADC/SBB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if (rsp_valid_q && rsp_ready && mode_q == MODE_ARITH) begin
            sticky_q <= rsp_flags_q.carry;
        end
    end

    assign sticky = sticky_q;
`else
    assign sticky = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_valid) state_d = SHIFT;
            SHIFT:   if (last) state_d = DONE;
            DONE:    if (rsp_valid_q && rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        slice_a    = 1'b0;
        slice_b    = 1'b0;
        slice_cin  = 1'b0;
        slice_mode = 1'b0;
        slice_op   = 3'b000;
        if (in_shift) begin
            slice_a    = a_sh[0];
            slice_b    = b_sh[0];
            slice_cin  = (cnt_q == '0) ? cin0_q : carry_q;
            slice_mode = mode_q;
            slice_op   = op_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh         <= '0;
            b_sh         <= '0;
            res_sh       <= '0;
            mode_q       <= 1'b0;
            op_q         <= 3'b000;
            cnt_q        <= '0;
            cin0_q       <= 1'b0;
            carry_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        a_sh    <= req_a;
                        b_sh    <= req_b;
                        mode_q  <= req_mode;
                        op_q    <= req_op;
                        cnt_q   <= '0;
                        cin0_q  <= cin0_lookup(req_mode, req_op, sticky);
                        carry_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    res_sh  <= {slice_out, res_sh[WIDTH-1:1]};
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    carry_q <= slice_carry;
                    cnt_q   <= cnt_q + 1'b1;
                end
                DONE: begin
                    // response registers load once, then hold until taken
                    if (!rsp_valid_q) begin
                        rsp_valid_q  <= 1'b1;
                        rsp_result_q <= res_sh;
                        rsp_flags_q  <= flags;
                    end else if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    serial_flag_tracker u_flags (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .shift_en  (in_shift),
        .last      (last),
        .mode      (mode_q),
        .slice_out (slice_out),
        .slice_cin (slice_cin),
        .carry     (carry_q),
        .msb       (res_sh[WIDTH-1]),
        .flags     (flags)
    );

    assign req_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_carry    = rsp_flags_q.carry;
    assign rsp_zero     = rsp_flags_q.zero;
    assign rsp_sign     = rsp_flags_q.sign;
    assign rsp_overflow = rsp_flags_q.overflow;

endmodule
